// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, redirect and decode-side signals of the fetch unit.
interface fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int INST_W = 16
);
    logic [ADDR_W-1:0] im_address;
    logic              im_req;
    logic [INST_W-1:0] im_inst;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              if_valid;
    logic [INST_W-1:0] if_inst;
    logic [ADDR_W-1:0] if_pc;
    logic              id_ready;
    modport master (
        output im_address, im_req, if_valid, if_inst, if_pc,
        input  im_inst, br_taken, br_target, id_ready
    );
    modport slave (
        input  im_address, im_req, if_valid, if_inst, if_pc,
        output im_inst, br_taken, br_target, id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetcher with a small return queue, decode handshake and branch redirect.
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INST_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 2,
    parameter int                DEPTH    = 2
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_RESET, S_FETCH, S_FULL} state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] fetch_pc, inflight_pc;
    logic              inflight, issue, push, pop, has_room;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    logic [PTR_W-1:0]  head, tail;
    logic [INST_W-1:0] inst_q [DEPTH];
    logic [ADDR_W-1:0] pc_q [DEPTH];

    // Issue credit counts the entry already in flight, so a push can never overflow the queue.
    assign pop       = bus.if_valid && bus.id_ready;
    assign push      = inflight && !bus.br_taken;
    assign occupancy = (CNT_W+1)'(count) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    assign has_room  = occupancy < (CNT_W+1)'(DEPTH);

    assign bus.im_address = fetch_pc;
    assign bus.im_req     = issue;
    assign bus.if_valid   = count != '0;
    assign bus.if_inst    = bus.if_valid ? inst_q[head] : '0;
    assign bus.if_pc      = bus.if_valid ? pc_q[head] : '0;

    always_comb begin
        issue      = 1'b0;
        next_state = state;
        case (state)
            S_RESET: next_state = S_FETCH;
            S_FETCH: begin
                issue      = has_room && !bus.br_taken;
                next_state = (issue || bus.br_taken) ? S_FETCH : S_FULL;
            end
            S_FULL:  next_state = (pop || bus.br_taken) ? S_FETCH : S_FULL;
            default: next_state = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RESET;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            state    <= next_state;
            inflight <= issue;
            if (issue)
                inflight_pc <= fetch_pc;
            if (bus.br_taken)
                fetch_pc <= bus.br_target;
            else if (issue)
                fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
            // A redirect empties the queue and drops the response arriving this edge.
            if (bus.br_taken) begin
                count <= '0;
                head  <= '0;
                tail  <= '0;
            end else begin
                if (push)
                    tail <= tail + PTR_W'(1);
                if (pop)
                    head <= head + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[tail] <= bus.im_inst;
            pc_q[tail]   <= inflight_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios for fetch_unit; memory returns address ^ 16'hA5A5 one cycle after request.
module tb_fetch_unit;
    logic clk, rst;
    int   tot, bad;

    fetch_unit_if #(.ADDR_W(16), .INST_W(16)) bus ();
    fetch_unit_if #(.ADDR_W(16), .INST_W(16)) wbus ();

    fetch_unit #(.ADDR_W(16), .INST_W(16), .RESET_PC(16'h0000), .PC_STEP(2), .DEPTH(2))
        dut (.clk(clk), .rst(rst), .bus(bus));
    fetch_unit #(.ADDR_W(16), .INST_W(16), .RESET_PC(16'hFFFC), .PC_STEP(2), .DEPTH(2))
        dut_w (.clk(clk), .rst(rst), .bus(wbus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.im_inst  <= bus.im_req ? (bus.im_address ^ 16'hA5A5) : 16'hDEAD;
        wbus.im_inst <= wbus.im_req ? (wbus.im_address ^ 16'hA5A5) : 16'hDEAD;
    end

    always @(posedge clk)
        if (!rst && dut.inflight && !bus.br_taken && !(bus.if_valid && bus.id_ready) && dut.count == 2'd2) begin
            bad++;
            $display("FAIL overflow: push into full queue at %0t", $time);
        end

    task automatic do_reset();
        rst = 1'b1;
        bus.id_ready = 1'b1;
        bus.br_taken = 1'b0;
        bus.br_target = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.id_ready = 1'b1;
        bus.br_taken = 1'b0;
        bus.br_target = '0;
        repeat (2) @(negedge clk);
        tot += 5;
        if (bus.im_req !== 1'b0) begin bad++; $display("FAIL reset im_req got=%0b want=0", bus.im_req); end
        if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL reset if_valid got=%0b want=0", bus.if_valid); end
        if (bus.im_address !== 16'h0000) begin bad++; $display("FAIL reset im_address got=%h want=0000", bus.im_address); end
        if (bus.if_inst !== 16'h0000) begin bad++; $display("FAIL reset if_inst got=%h want=0000", bus.if_inst); end
        if (bus.if_pc !== 16'h0000) begin bad++; $display("FAIL reset if_pc got=%h want=0000", bus.if_pc); end
        rst = 1'b0;
    endtask

    task automatic test_startup();
        logic [15:0] a, p;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a = 16'(2 * k);
            tot += 2;
            if (bus.im_req !== 1'b1) begin bad++; $display("FAIL startup[%0d] im_req got=%0b want=1", k, bus.im_req); end
            if (bus.im_address !== a) begin bad++; $display("FAIL startup[%0d] im_address got=%h want=%h", k, bus.im_address, a); end
            if (k >= 2) begin
                p = 16'(2 * (k - 2));
                tot += 3;
                if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL startup[%0d] if_valid got=%0b want=1", k, bus.if_valid); end
                if (bus.if_pc !== p) begin bad++; $display("FAIL startup[%0d] if_pc got=%h want=%h", k, bus.if_pc, p); end
                if (bus.if_inst !== (p ^ 16'hA5A5)) begin bad++; $display("FAIL startup[%0d] if_inst got=%h want=%h", k, bus.if_inst, p ^ 16'hA5A5); end
            end else begin
                tot++;
                if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL startup[%0d] if_valid got=%0b want=0", k, bus.if_valid); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic        ev [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [15:0] ep [4] = '{16'h0006, 16'h0000, 16'h0008, 16'h000A};
        logic [15:0] ea [4] = '{16'h0008, 16'h000A, 16'h000C, 16'h000E};
        bus.id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tot += 4;
            if (bus.im_req !== 1'b0) begin bad++; $display("FAIL stall[%0d] im_req got=%0b want=0", k, bus.im_req); end
            if (bus.im_address !== 16'h0008) begin bad++; $display("FAIL stall[%0d] im_address got=%h want=0008", k, bus.im_address); end
            if (bus.if_pc !== 16'h0004) begin bad++; $display("FAIL stall[%0d] if_pc got=%h want=0004", k, bus.if_pc); end
            if (bus.if_inst !== 16'hA5A1) begin bad++; $display("FAIL stall[%0d] if_inst got=%h want=A5A1", k, bus.if_inst); end
        end
        bus.id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tot += 2;
            if (bus.if_valid !== ev[k]) begin bad++; $display("FAIL drain[%0d] if_valid got=%0b want=%0b", k, bus.if_valid, ev[k]); end
            if (bus.im_address !== ea[k]) begin bad++; $display("FAIL drain[%0d] im_address got=%h want=%h", k, bus.im_address, ea[k]); end
            if (ev[k]) begin
                tot++;
                if (bus.if_pc !== ep[k]) begin bad++; $display("FAIL drain[%0d] if_pc got=%h want=%h", k, bus.if_pc, ep[k]); end
            end
        end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        repeat (5) @(negedge clk);
        bus.br_taken = 1'b1;
        bus.br_target = 16'h0010;
        #1;
        tot += 2;
        if (bus.im_req !== 1'b0) begin bad++; $display("FAIL redir im_req got=%0b want=0", bus.im_req); end
        if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL redir if_valid got=%0b want=1", bus.if_valid); end
        @(negedge clk);
        bus.br_taken = 1'b0;
        #1;
        tot += 3;
        if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL redir+1 if_valid got=%0b want=0", bus.if_valid); end
        if (bus.im_address !== 16'h0010) begin bad++; $display("FAIL redir+1 im_address got=%h want=0010", bus.im_address); end
        if (bus.im_req !== 1'b1) begin bad++; $display("FAIL redir+1 im_req got=%0b want=1", bus.im_req); end
        @(negedge clk);
        tot++;
        if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL redir+2 if_valid got=%0b want=0", bus.if_valid); end
        @(negedge clk);
        tot += 3;
        if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL redir+3 if_valid got=%0b want=1", bus.if_valid); end
        if (bus.if_pc !== 16'h0010) begin bad++; $display("FAIL redir+3 if_pc got=%h want=0010", bus.if_pc); end
        if (bus.if_inst !== 16'hA5B5) begin bad++; $display("FAIL redir+3 if_inst got=%h want=A5B5", bus.if_inst); end
        @(negedge clk);
        tot += 2;
        if (bus.if_pc !== 16'h0012) begin bad++; $display("FAIL redir+4 if_pc got=%h want=0012", bus.if_pc); end
        if (bus.if_inst !== 16'hA5B7) begin bad++; $display("FAIL redir+4 if_inst got=%h want=A5B7", bus.if_inst); end
    endtask

    task automatic test_redirect_full_pop();
        do_reset();
        repeat (5) @(negedge clk);
        bus.id_ready = 1'b0;
        @(negedge clk);
        bus.id_ready = 1'b1;
        bus.br_taken = 1'b1;
        bus.br_target = 16'h0020;
        #1;
        tot += 2;
        if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL fullredir if_valid got=%0b want=1", bus.if_valid); end
        if (bus.im_req !== 1'b0) begin bad++; $display("FAIL fullredir im_req got=%0b want=0", bus.im_req); end
        @(negedge clk);
        bus.br_taken = 1'b0;
        #1;
        tot += 2;
        if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL fullredir+1 if_valid got=%0b want=0", bus.if_valid); end
        if (bus.im_address !== 16'h0020) begin bad++; $display("FAIL fullredir+1 im_address got=%h want=0020", bus.im_address); end
        repeat (2) @(negedge clk);
        tot += 3;
        if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL fullredir+3 if_valid got=%0b want=1", bus.if_valid); end
        if (bus.if_pc !== 16'h0020) begin bad++; $display("FAIL fullredir+3 if_pc got=%h want=0020", bus.if_pc); end
        if (bus.if_inst !== 16'hA585) begin bad++; $display("FAIL fullredir+3 if_inst got=%h want=A585", bus.if_inst); end
    endtask

    task automatic test_wrap();
        logic [15:0] ea [6] = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002, 16'h0004, 16'h0006};
        logic [15:0] p;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tot += 2;
            if (wbus.im_address !== ea[k]) begin bad++; $display("FAIL wrap[%0d] im_address got=%h want=%h", k, wbus.im_address, ea[k]); end
            if (wbus.if_valid !== (k >= 2)) begin bad++; $display("FAIL wrap[%0d] if_valid got=%0b want=%0b", k, wbus.if_valid, k >= 2); end
            if (k >= 2) begin
                p = ea[k-2];
                tot += 2;
                if (wbus.if_pc !== p) begin bad++; $display("FAIL wrap[%0d] if_pc got=%h want=%h", k, wbus.if_pc, p); end
                if (wbus.if_inst !== (p ^ 16'hA5A5)) begin bad++; $display("FAIL wrap[%0d] if_inst got=%h want=%h", k, wbus.if_inst, p ^ 16'hA5A5); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (5) @(negedge clk);
        bus.id_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        tot += 3;
        if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL midrst if_valid got=%0b want=0", bus.if_valid); end
        if (bus.im_req !== 1'b0) begin bad++; $display("FAIL midrst im_req got=%0b want=0", bus.im_req); end
        if (bus.im_address !== 16'h0000) begin bad++; $display("FAIL midrst im_address got=%h want=0000", bus.im_address); end
        rst = 1'b0;
        bus.id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tot += 2;
            if (bus.im_address !== 16'(2 * k)) begin bad++; $display("FAIL midrst[%0d] im_address got=%h want=%h", k, bus.im_address, 16'(2 * k)); end
            if (bus.if_valid !== (k >= 2)) begin bad++; $display("FAIL midrst[%0d] if_valid got=%0b want=%0b", k, bus.if_valid, k >= 2); end
            if (k >= 2) begin
                tot += 2;
                if (bus.if_pc !== 16'(2 * (k - 2))) begin bad++; $display("FAIL midrst[%0d] if_pc got=%h want=%h", k, bus.if_pc, 16'(2 * (k - 2))); end
                if (bus.if_inst !== (16'(2 * (k - 2)) ^ 16'hA5A5)) begin bad++; $display("FAIL midrst[%0d] if_inst got=%h", k, bus.if_inst); end
            end
        end
    endtask

    initial begin
        tot = 0;
        bad = 0;
        wbus.id_ready = 1'b1;
        wbus.br_taken = 1'b0;
        wbus.br_target = '0;
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_full_pop();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
